// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst sequencer: FSM states, the fallback
// SCLK divider and the FIFO occupancy-width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_DONE,
        S_FINISH
    } seq_state_e;

    localparam logic [15:0] SPI_DEFAULT_CLK_DIV = 16'd4;

    // Occupancy counters need one extra bit so that "full" is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_byte_fifo.sv
// First-word-fall-through byte FIFO with occupancy count; the head byte is
// visible on rd_data_o whenever the FIFO is not empty.
module spi_byte_fifo import spi_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en_i,
    input  logic [7:0]                    wr_data_i,
    input  logic                          rd_en_i,
    output logic [7:0]                    rd_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [count_width(DEPTH)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic          doWrite;
    logic          doRead;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A write into a full FIFO is still taken when a read frees a slot in the same cycle.
    assign doRead  = rd_en_i & ~empty_o;
    assign doWrite = wr_en_i & (~full_o | doRead);

    assign rd_data_o = empty_o ? 8'h00 : mem_q[rdPtr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doWrite) wrPtr_q <= wrPtr_q + 1'b1;
            if (doRead)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doWrite, doRead})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) mem_q[wrPtr_q] <= wr_data_i;
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Byte-burst sequencer in front of spi_master: drains a TX FIFO one byte per
// start/busy/done handshake and collects the returned bytes into an RX FIFO.
module spi_xfer_sequencer import spi_pkg::*; #(
    parameter int          FIFO_DEPTH      = 16,
    parameter logic [15:0] DEFAULT_CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               wr_en,
    input  logic [7:0]                         wr_data,
    input  logic                               rd_en,
    output logic [7:0]                         rd_data,
    output logic                               tx_full,
    output logic                               tx_empty,
    output logic                               rx_full,
    output logic                               rx_empty,
    output logic [count_width(FIFO_DEPTH)-1:0] tx_count,
    output logic [count_width(FIFO_DEPTH)-1:0] rx_count,
    input  logic                               go,
    input  logic                               abort,
    input  logic [7:0]                         xfer_len,
    input  logic [15:0]                        clk_div_cfg,
    output logic                               seq_busy,
    output logic                               seq_done,
    output logic                               irq,
    output logic                               aborted,
    output logic                               rx_ovf,
    output logic                               m_start,
    output logic [7:0]                         m_tx_data,
    output logic [15:0]                        m_clk_div,
    input  logic                               m_busy,
    input  logic                               m_done,
    input  logic [7:0]                         m_rx_data
);

    seq_state_e  state_q;
    logic [7:0]  remaining_q;
    logic        abortPend_q;
    logic        aborted_q;
    logic        rxOvf_q;
    logic        mStart_q;
    logic        seqDone_q;
    logic [7:0]  mTxData_q;
    logic [15:0] mClkDiv_q;

    logic [7:0]  txHead;
    logic        txPop;
    logic        rxPush;
    logic        abortSeen;

    assign abortSeen = abort | abortPend_q;
    assign txPop     = (state_q == S_LOAD) && !abortSeen && !tx_empty;
    assign rxPush    = (state_q == S_WAIT_DONE) && m_done;

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_txFifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (txPop),
        .rd_data_o (txHead),
        .full_o    (tx_full),
        .empty_o   (tx_empty),
        .count_o   (tx_count)
    );

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rxFifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (rxPush),
        .wr_data_i (m_rx_data),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .full_o    (rx_full),
        .empty_o   (rx_empty),
        .count_o   (rx_count)
    );

    // Burst control; every handshake output comes straight from a register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            remaining_q <= 8'd0;
            abortPend_q <= 1'b0;
            aborted_q   <= 1'b0;
            rxOvf_q     <= 1'b0;
            mStart_q    <= 1'b0;
            seqDone_q   <= 1'b0;
            mTxData_q   <= 8'h00;
            mClkDiv_q   <= DEFAULT_CLK_DIV;
        end else begin
            seqDone_q <= 1'b0;
            if (state_q != S_IDLE && abort) abortPend_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (go && xfer_len != 8'd0) begin
                        remaining_q <= xfer_len;
                        mClkDiv_q   <= (clk_div_cfg == 16'd0) ? DEFAULT_CLK_DIV : clk_div_cfg;
                        aborted_q   <= 1'b0;
                        rxOvf_q     <= 1'b0;
                        abortPend_q <= 1'b0;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abortSeen) begin
                        aborted_q <= 1'b1;
                        seqDone_q <= 1'b1;
                        state_q   <= S_FINISH;
                    end else if (!tx_empty) begin
                        mTxData_q <= txHead;
                        mStart_q  <= 1'b1;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (m_busy) begin
                        mStart_q <= 1'b0;
                        state_q  <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (m_done) begin
                        remaining_q <= remaining_q - 8'd1;
                        // Full RX only drops the byte if the host is not reading in this same cycle.
                        if (rx_full && !rd_en) rxOvf_q <= 1'b1;
                        if (remaining_q == 8'd1 || abortSeen) begin
                            if (abortSeen) aborted_q <= 1'b1;
                            seqDone_q <= 1'b1;
                            state_q   <= S_FINISH;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_FINISH: begin
                    abortPend_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign seq_busy  = (state_q != S_IDLE);
    assign seq_done  = seqDone_q;
    assign irq       = seqDone_q;
    assign aborted   = aborted_q;
    assign rx_ovf    = rxOvf_q;
    assign m_start   = mStart_q;
    assign m_tx_data = mTxData_q;
    assign m_clk_div = mClkDiv_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer with a behavioural spi_master
// responder and a queue-based model of the two FIFOs and the burst rules.
module tb_spi_xfer_sequencer;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en, rd_en, go, abort;
    logic [7:0]    wr_data, xfer_len;
    logic [15:0]   clk_div_cfg;
    logic [7:0]    rd_data, m_tx_data, m_rx_data;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic          seq_busy, seq_done, irq, aborted, rx_ovf;
    logic          m_start, m_busy, m_done;
    logic [15:0]   m_clk_div;

    int tests    = 0;
    int failures = 0;
    int doneCnt  = 0;
    int irqCnt   = 0;
    int masterXfers = 0;

    logic [7:0]  rxMask = 8'h00;
    logic [7:0]  txQ[$];
    logic [7:0]  rxQ[$];
    logic [15:0] expDiv;
    logic        expOvf;
    logic        expAborted;

    always #5 clk = ~clk;

    spi_xfer_sequencer #(.FIFO_DEPTH(DEPTH), .DEFAULT_CLK_DIV(16'd4)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
        .tx_count(tx_count), .rx_count(rx_count),
        .go(go), .abort(abort), .xfer_len(xfer_len), .clk_div_cfg(clk_div_cfg),
        .seq_busy(seq_busy), .seq_done(seq_done), .irq(irq),
        .aborted(aborted), .rx_ovf(rx_ovf),
        .m_start(m_start), .m_tx_data(m_tx_data), .m_clk_div(m_clk_div),
        .m_busy(m_busy), .m_done(m_done), .m_rx_data(m_rx_data)
    );

    // Completion pulses are tallied continuously so tests can check for exactly one.
    always @(posedge clk) begin
        if (seq_done === 1'b1) doneCnt++;
        if (irq === 1'b1) irqCnt++;
    end

    // Behavioural spi_master: random accept latency and transfer length, MISO = MOSI ^ rxMask.
    int         mState;
    int         mDelay;
    int         mBits;
    logic [7:0] mLatched;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            m_rx_data <= 8'h00;
            mState    <= 0;
        end else begin
            case (mState)
                0: begin
                    m_done <= 1'b0;
                    if (m_start) begin
                        mLatched <= m_tx_data;
                        mDelay   <= $urandom_range(0, 2);
                        mState   <= 1;
                    end
                end
                1: begin
                    if (mDelay == 0) begin
                        m_busy      <= 1'b1;
                        masterXfers <= masterXfers + 1;
                        mBits       <= $urandom_range(1, 4);
                        mState      <= 2;
                    end else begin
                        mDelay <= mDelay - 1;
                    end
                end
                default: begin
                    if (mBits == 1) begin
                        m_busy    <= 1'b0;
                        m_done    <= 1'b1;
                        m_rx_data <= mLatched ^ rxMask;
                        mState    <= 0;
                    end else begin
                        mBits <= mBits - 1;
                    end
                end
            endcase
        end
    end

    // Reference model: burst acceptance and byte flow through the two queues.
    function automatic void modelGo(input int len, input logic [15:0] div);
        if (len != 0) begin
            expDiv     = (div == 16'd0) ? 16'd4 : div;
            expOvf     = 1'b0;
            expAborted = 1'b0;
        end
    endfunction

    function automatic void modelBurst(input int n, input int abortAfter);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            if (txQ.size() == 0) break;
            b = txQ.pop_front();
            if (rxQ.size() < DEPTH) rxQ.push_back(b ^ rxMask);
            else expOvf = 1'b1;
            if (abortAfter == i + 1) begin
                expAborted = 1'b1;
                break;
            end
        end
    endfunction

    function automatic void modelReset();
        txQ.delete();
        rxQ.delete();
        expDiv     = 16'd4;
        expOvf     = 1'b0;
        expAborted = 1'b0;
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        if (txQ.size() < DEPTH) txQ.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic popByte(output logic [7:0] b);
        @(negedge clk);
        b     = rd_data;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic startBurst(input int len, input logic [15:0] div);
        @(negedge clk);
        go          = 1'b1;
        xfer_len    = len[7:0];
        clk_div_cfg = div;
        modelGo(len, div);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit seen);
        int k = 0;
        while (seq_done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        seen = (seq_done === 1'b1);
    endtask

    task automatic waitBusy(input int budget, output bit seen);
        int k = 0;
        while (m_busy !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        seen = (m_busy === 1'b1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({tx_empty, rx_empty, tx_full, rx_full, seq_busy, seq_done, irq, aborted, rx_ovf, m_start} !== 10'b1100000000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected %b", {tx_empty, rx_empty, tx_full, rx_full, seq_busy, seq_done, irq, aborted, rx_ovf, m_start}, 10'b1100000000);
        end
        tests++;
        if (m_clk_div !== 16'd4 || tx_count !== '0 || rx_count !== '0 || m_tx_data !== 8'h00 || rd_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_values: div %0d txc %0d rxc %0d txd %h rdd %h expected 4 0 0 00 00", m_clk_div, tx_count, rx_count, m_tx_data, rd_data);
        end
        reset_n = 1'b1;
        modelReset();
        @(negedge clk);
        tests++;
        if (seq_busy !== 1'b0 || tx_empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset: busy %b tx_empty %b expected 0 1", seq_busy, tx_empty);
        end
    endtask

    task automatic test_basic;
        int d0, i0, x0;
        bit seen;
        logic [7:0] got, exp;
        rxMask = 8'h00;
        applyStimulus(8'hA5);
        applyStimulus(8'h3C);
        d0 = doneCnt; i0 = irqCnt; x0 = masterXfers;
        @(negedge clk);
        go = 1'b1; xfer_len = 8'd2; clk_div_cfg = 16'd0;
        modelGo(2, 16'd0);
        @(negedge clk);
        go = 1'b0;
        tests++;
        if (seq_busy !== 1'b1 || m_start !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_go_latency: busy %b start %b expected 1 0", seq_busy, m_start);
        end
        @(negedge clk);
        tests++;
        if (m_start !== 1'b1 || m_tx_data !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL basic_first_start: start %b data %h expected 1 a5", m_start, m_tx_data);
        end
        waitDone(300, seen);
        tests++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL basic_done_timeout: seq_done %b expected 1", seq_done);
        end
        tests++;
        if (m_clk_div !== expDiv) begin
            failures++;
            $display("[TB] FAIL basic_clk_div: got %0d expected %0d", m_clk_div, expDiv);
        end
        @(negedge clk);
        tests++;
        if (seq_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_busy_fall: got %b expected 0", seq_busy);
        end
        tests++;
        if (doneCnt - d0 != 1 || irqCnt - i0 != 1 || masterXfers - x0 != 2) begin
            failures++;
            $display("[TB] FAIL basic_pulses: done %0d irq %0d xfers %0d expected 1 1 2", doneCnt - d0, irqCnt - i0, masterXfers - x0);
        end
        modelBurst(2, 0);
        tests++;
        if (rx_count !== CW'(rxQ.size())) begin
            failures++;
            $display("[TB] FAIL basic_rx_count: got %0d expected %0d", rx_count, rxQ.size());
        end
        while (rxQ.size() > 0) begin
            exp = rxQ.pop_front();
            popByte(got);
            tests++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL basic_rx_data: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_stall;
        int x0;
        bit seen;
        logic [15:0] div;
        logic [7:0] got, exp;
        rxMask = 8'($urandom);
        div = 16'($urandom_range(1, 200));
        applyStimulus(8'($urandom));
        x0 = masterXfers;
        startBurst(3, div);
        repeat (30) @(negedge clk);
        tests++;
        if (seq_busy !== 1'b1 || m_start !== 1'b0 || masterXfers - x0 != 1 || rx_count !== CW'(1)) begin
            failures++;
            $display("[TB] FAIL stall_in_load: busy %b start %b xfers %0d rxc %0d expected 1 0 1 1", seq_busy, m_start, masterXfers - x0, rx_count);
        end
        applyStimulus(8'($urandom));
        applyStimulus(8'($urandom));
        waitDone(300, seen);
        tests++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL stall_done_timeout: seq_done %b expected 1", seq_done);
        end
        modelBurst(3, 0);
        tests++;
        if (rx_count !== CW'(rxQ.size()) || m_clk_div !== expDiv) begin
            failures++;
            $display("[TB] FAIL stall_result: rxc %0d div %0d expected %0d %0d", rx_count, m_clk_div, rxQ.size(), expDiv);
        end
        while (rxQ.size() > 0) begin
            exp = rxQ.pop_front();
            popByte(got);
            tests++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL stall_rx_data: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_rx_overflow;
        bit seen;
        logic [7:0] got, exp;
        rxMask = 8'($urandom);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(8'($urandom));
        startBurst(DEPTH - 1, 16'd0);
        waitDone(2000, seen);
        modelBurst(DEPTH - 1, 0);
        tests++;
        if (!seen || rx_count !== CW'(DEPTH - 1) || rx_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_prefill: seen %b rxc %0d ovf %b expected 1 %0d 0", seen, rx_count, rx_ovf, DEPTH - 1);
        end
        applyStimulus(8'($urandom));
        applyStimulus(8'($urandom));
        startBurst(2, 16'd3);
        waitDone(300, seen);
        modelBurst(2, 0);
        tests++;
        if (!seen || rx_ovf !== expOvf || rx_count !== CW'(rxQ.size()) || rx_full !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_result: seen %b ovf %b rxc %0d full %b expected 1 %b %0d 1", seen, rx_ovf, rx_count, rx_full, expOvf, rxQ.size());
        end
        while (rxQ.size() > 0) begin
            exp = rxQ.pop_front();
            popByte(got);
            tests++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL ovf_rx_data: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_abort;
        bit seen;
        logic [7:0] got, exp;
        rxMask = 8'($urandom);
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom));
        startBurst(4, 16'd0);
        waitBusy(100, seen);
        tests++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL abort_busy_timeout: m_busy %b expected 1", m_busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        waitDone(300, seen);
        modelBurst(4, 1);
        tests++;
        if (!seen || aborted !== expAborted || rx_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_flags: seen %b aborted %b ovf %b expected 1 %b 0", seen, aborted, rx_ovf, expAborted);
        end
        tests++;
        if (rx_count !== CW'(rxQ.size()) || tx_count !== CW'(txQ.size())) begin
            failures++;
            $display("[TB] FAIL abort_counts: rxc %0d txc %0d expected %0d %0d", rx_count, tx_count, rxQ.size(), txQ.size());
        end
        startBurst(3, 16'd0);
        waitDone(300, seen);
        modelBurst(3, 0);
        tests++;
        if (!seen || aborted !== 1'b0 || tx_count !== CW'(0) || rx_count !== CW'(rxQ.size())) begin
            failures++;
            $display("[TB] FAIL abort_cleared: seen %b aborted %b txc %0d rxc %0d expected 1 0 0 %0d", seen, aborted, tx_count, rx_count, rxQ.size());
        end
        while (rxQ.size() > 0) begin
            exp = rxQ.pop_front();
            popByte(got);
            tests++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL abort_rx_data: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_fifo_edges;
        bit seen;
        logic [7:0] got, exp, extra;
        rxMask = 8'($urandom);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(8'($urandom));
        tests++;
        if (tx_count !== CW'(DEPTH) || tx_full !== 1'b1 || txQ.size() != DEPTH) begin
            failures++;
            $display("[TB] FAIL fifo_tx_full: txc %0d full %b expected %0d 1", tx_count, tx_full, DEPTH);
        end
        extra = 8'($urandom);
        @(negedge clk);
        go = 1'b1; xfer_len = 8'd1; clk_div_cfg = 16'd0;
        modelGo(1, 16'd0);
        @(negedge clk);
        go = 1'b0; wr_en = 1'b1; wr_data = extra;
        @(negedge clk);
        wr_en = 1'b0;
        modelBurst(1, 0);
        txQ.push_back(extra);
        tests++;
        if (tx_count !== CW'(DEPTH) || tx_full !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fifo_rw_at_full: txc %0d full %b expected %0d 1", tx_count, tx_full, DEPTH);
        end
        waitDone(300, seen);
        exp = rxQ.pop_front();
        popByte(got);
        tests++;
        if (!seen || got !== exp) begin
            failures++;
            $display("[TB] FAIL fifo_single_rx: seen %b got %h expected %h", seen, got, exp);
        end
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        tests++;
        if (rx_count !== CW'(0) || rx_empty !== 1'b1 || rd_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL fifo_read_empty: rxc %0d empty %b rdd %h expected 0 1 00", rx_count, rx_empty, rd_data);
        end
        startBurst(DEPTH, 16'd2);
        waitDone(3000, seen);
        modelBurst(DEPTH, 0);
        tests++;
        if (!seen || rx_count !== CW'(DEPTH) || rx_full !== 1'b1 || tx_empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fifo_full_burst: seen %b rxc %0d full %b tx_empty %b expected 1 %0d 1 1", seen, rx_count, rx_full, tx_empty, DEPTH);
        end
        while (rxQ.size() > 0) begin
            exp = rxQ.pop_front();
            popByte(got);
            tests++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL fifo_rx_data: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        bit seen;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        startBurst(2, 16'd7);
        waitBusy(100, seen);
        d0 = doneCnt;
        reset_n = 1'b0;
        #1;
        tests++;
        if (!seen || m_start !== 1'b0 || seq_busy !== 1'b0 || tx_count !== CW'(0) || rx_count !== CW'(0) || tx_empty !== 1'b1 || rx_empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mid_clear: seen %b start %b busy %b txc %0d rxc %0d expected 1 0 0 0 0", seen, m_start, seq_busy, tx_count, rx_count);
        end
        tests++;
        if (m_clk_div !== 16'd4 || seq_done !== 1'b0 || irq !== 1'b0 || aborted !== 1'b0 || rx_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_outputs: div %0d done %b irq %b expected 4 0 0", m_clk_div, seq_done, irq);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        modelReset();
        repeat (10) @(negedge clk);
        tests++;
        if (doneCnt != d0) begin
            failures++;
            $display("[TB] FAIL reset_mid_no_done: pulses %0d expected 0", doneCnt - d0);
        end
        startBurst(0, 16'd9);
        repeat (4) @(negedge clk);
        tests++;
        if (seq_busy !== 1'b0 || m_clk_div !== expDiv) begin
            failures++;
            $display("[TB] FAIL zero_len_go: busy %b div %0d expected 0 %0d", seq_busy, m_clk_div, expDiv);
        end
    endtask

    task automatic test_random;
        int n;
        bit seen;
        logic [15:0] div;
        logic [7:0] got, exp;
        for (int iter = 0; iter < 6; iter++) begin
            n      = $urandom_range(1, 8);
            div    = 16'($urandom_range(0, 15));
            rxMask = 8'($urandom);
            for (int i = 0; i < n; i++) applyStimulus(8'($urandom));
            startBurst(n, div);
            @(negedge clk);
            go = 1'b1; xfer_len = 8'd5; clk_div_cfg = 16'h1234;
            @(negedge clk);
            go = 1'b0;
            waitDone(1000, seen);
            modelBurst(n, 0);
            tests++;
            if (!seen || m_clk_div !== expDiv || rx_count !== CW'(rxQ.size()) || tx_count !== CW'(txQ.size())) begin
                failures++;
                $display("[TB] FAIL random_burst[%0d]: seen %b div %0d rxc %0d txc %0d expected 1 %0d %0d %0d", iter, seen, m_clk_div, rx_count, tx_count, expDiv, rxQ.size(), txQ.size());
            end
            while (rxQ.size() > 0) begin
                exp = rxQ.pop_front();
                popByte(got);
                tests++;
                if (got !== exp) begin
                    failures++;
                    $display("[TB] FAIL random_rx_data[%0d]: got %h expected %h", iter, got, exp);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; go = 1'b0; abort = 1'b0;
        wr_data = 8'h00; xfer_len = 8'd0; clk_div_cfg = 16'd0;
        modelReset();
        test_reset();
        test_basic();
        test_stall();
        test_rx_overflow();
        test_abort();
        test_fifo_edges();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
